my_rr_arbiter: RTL

MY_RR_ARBITER -- requirements
Module: my_rr_arbiter

---
 rtl/my_rr_arbiter_if.sv | 18 +
 rtl/my_rr_arbiter.sv | 61 ++++++
 2 files changed

// File: rtl/my_rr_arbiter_if.sv
// my_rr_arbiter_if: request lanes, grant/ack and muxed output stream of the round-robin arbiter
interface my_rr_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4
);
  logic [CTRL_WIDTH-1:0] req, req_last, grant, ack;
  logic [DATA_WIDTH*CTRL_WIDTH-1:0] req_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid, out_ready, out_last, busy;
  modport slave (
    input req, req_last, req_data, out_ready,
    output grant, ack, out_valid, out_data, out_last, busy
  );
  modport master (
    output req, req_last, req_data, out_ready,
    input grant, ack, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/my_rr_arbiter.sv
// my_rr_arbiter: burst-locked round-robin arbiter with registered one-hot grant and muxed output
module my_rr_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  my_rr_arbiter_if.slave bus
);
  localparam int PW = $clog2(CTRL_WIDTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [CTRL_WIDTH-1:0] grant, grant_nxt, pick;
  logic [PW-1:0] ptr, ptr_nxt, g;
  logic [DATA_WIDTH-1:0] data;
  logic xfer_last;
  // scan from lowest priority to highest so the nearest request at/after ptr wins
  always_comb begin
    pick = '0;
    for (int i = CTRL_WIDTH - 1; i >= 0; i--)
      if (bus.req[(int'(ptr) + i) % CTRL_WIDTH]) pick = CTRL_WIDTH'(1) << ((int'(ptr) + i) % CTRL_WIDTH);
  end
  always_comb begin
    g = '0;
    data = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (grant[i]) g = PW'(i);
      data = data | (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end
  assign bus.busy = state == BUSY;
  assign bus.grant = grant;
  assign bus.out_valid = bus.busy & |(bus.req & grant);
  assign bus.out_last = bus.busy & |(bus.req_last & grant);
  assign bus.out_data = data;
  assign bus.ack = (bus.out_valid & bus.out_ready) ? grant : '0;
  assign xfer_last = bus.out_valid & bus.out_ready & bus.out_last;
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt = ptr;
    if (state == IDLE && |bus.req) begin
      state_nxt = BUSY;
      grant_nxt = pick;
    end else if (state == BUSY && xfer_last) begin
      state_nxt = IDLE;
      grant_nxt = '0;
      ptr_nxt = (int'(g) == CTRL_WIDTH - 1) ? '0 : g + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr <= ptr_nxt;
    end
endmodule
